// File: rtl/fan_pwm_driver.sv
// rtl/fan_pwm_driver.sv - saturating PID-to-PWM fan output stage with kick-start
// Duty updates are latched at PWM period boundaries only; a stopped fan is kicked at 100%.
module fan_pwm_driver #(
  parameter int PID_BITWIDTH  = 5,
  parameter int DUTY_BITWIDTH = 4,
  parameter int CLK_DIV       = 3,
  parameter int MIN_DUTY      = 3,
  parameter int KICK_PERIODS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic signed [PID_BITWIDTH-1:0]  pid_val,
  input  logic                            pid_valid,
  output logic                            pwm_out,
  output logic [DUTY_BITWIDTH-1:0]        duty_out,
  output logic                            kick_active,
  output logic                            period_start
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int KC_W  = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  localparam logic [PRE_W-1:0]         PRE_MAX   = PRE_W'(CLK_DIV - 1);
  localparam logic [DUTY_BITWIDTH-1:0] DUTY_MAX  = '1;
  localparam logic [KC_W-1:0]          KICK_LOAD = KC_W'(KICK_PERIODS - 1);
  localparam logic [31:0]              SAT_HI    = 32'((2 ** DUTY_BITWIDTH) - 1);
  localparam logic [31:0]              SAT_LO    = 32'(MIN_DUTY);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_KICK = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [PRE_W-1:0]           r_presc;
  logic [DUTY_BITWIDTH-1:0]   r_slot;
  logic [DUTY_BITWIDTH-1:0]   r_shadow;
  logic [DUTY_BITWIDTH-1:0]   r_duty;
  logic [DUTY_BITWIDTH-1:0]   w_duty_next;
  logic [KC_W-1:0]            r_kick_cnt;
  logic [KC_W-1:0]            w_kick_next;
  logic                       r_pwm;
  logic                       r_ps;
  logic                       w_pwm_next;
  logic                       w_tick;
  logic                       w_boundary;
  logic [31:0]                w_pid_mag;
  logic [DUTY_BITWIDTH-1:0]   w_sat;

  assign w_tick     = (r_presc == PRE_MAX);
  assign w_boundary = w_tick && (r_slot == DUTY_MAX);

  // Magnitude of a non-negative request; the sign bit is handled separately.
  assign w_pid_mag = 32'(pid_val[PID_BITWIDTH-2:0]);

  always_comb begin
    w_sat = '0;
    if (pid_val[PID_BITWIDTH-1]) begin
      w_sat = '0;
    end else if (w_pid_mag > SAT_HI) begin
      w_sat = DUTY_MAX;
    end else if ((w_pid_mag != 32'd0) && (w_pid_mag < SAT_LO)) begin
      w_sat = DUTY_BITWIDTH'(MIN_DUTY);
    end else begin
      w_sat = DUTY_BITWIDTH'(w_pid_mag);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_kick_next  = r_kick_cnt;
    w_duty_next  = r_duty;
    if (w_boundary) begin
      case (r_state)
        ST_STOP: begin
          if (r_shadow != '0) begin
            w_state_next = ST_KICK;
            w_kick_next  = KICK_LOAD;
          end
        end
        ST_KICK: begin
          if (r_kick_cnt != '0) begin
            w_kick_next = r_kick_cnt - KC_W'(1);
          end else if (r_shadow == '0) begin
            w_state_next = ST_STOP;
            w_duty_next  = '0;
          end else begin
            w_state_next = ST_RUN;
            w_duty_next  = r_shadow;
          end
        end
        ST_RUN: begin
          if (r_shadow == '0) begin
            w_state_next = ST_STOP;
            w_duty_next  = '0;
          end else begin
            w_duty_next = r_shadow;
          end
        end
        default: begin
          w_state_next = ST_STOP;
          w_duty_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_pwm_next = 1'b0;
    case (r_state)
      ST_KICK: w_pwm_next = 1'b1;
      ST_RUN:  w_pwm_next = (r_slot < r_duty);
      default: w_pwm_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_STOP;
      r_presc    <= '0;
      r_slot     <= '0;
      r_shadow   <= '0;
      r_duty     <= '0;
      r_kick_cnt <= '0;
      r_pwm      <= 1'b0;
      r_ps       <= 1'b0;
    end else if (ena) begin
      r_presc    <= w_tick ? '0 : r_presc + PRE_W'(1);
      if (w_tick) begin
        r_slot <= r_slot + DUTY_BITWIDTH'(1);
      end
      r_state    <= w_state_next;
      r_kick_cnt <= w_kick_next;
      r_duty     <= w_duty_next;
      r_pwm      <= w_pwm_next;
      r_ps       <= w_boundary;
      // The boundary decision above sees the pre-update shadow value.
      if (pid_valid) begin
        r_shadow <= w_sat;
      end
    end
  end

  // Registered outputs hold while disabled and are masked so the pin stays low.
  assign pwm_out      = r_pwm & ena;
  assign period_start = r_ps & ena;
  assign kick_active  = (r_state == ST_KICK);

  always_comb begin
    duty_out = '0;
    case (r_state)
      ST_KICK: duty_out = DUTY_MAX;
      ST_RUN:  duty_out = r_duty;
      default: duty_out = '0;
    endcase
  end

endmodule

// File: tb/tb_fan_pwm_driver.sv
// tb/tb_fan_pwm_driver.sv - directed self-checking bench for fan_pwm_driver
module tb_fan_pwm_driver;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic signed [4:0] pid_val;
  logic              pid_valid;
  logic              pwm_out;
  logic [3:0]        duty_out;
  logic              kick_active;
  logic              period_start;

  int checks;
  int passes;

  fan_pwm_driver #(
    .PID_BITWIDTH (5),
    .DUTY_BITWIDTH(4),
    .CLK_DIV      (3),
    .MIN_DUTY     (3),
    .KICK_PERIODS (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .pid_val     (pid_val),
    .pid_valid   (pid_valid),
    .pwm_out     (pwm_out),
    .duty_out    (duty_out),
    .kick_active (kick_active),
    .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic strobe(input logic signed [4:0] v);
    pid_val   = v;
    pid_valid = 1'b1;
    @(negedge clk);
    pid_valid = 1'b0;
  endtask

  task automatic wait_ps(output bit ok);
    int n;
    n = 0;
    while (!period_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = period_start;
  endtask

  task automatic wait_kick(input logic val, input int bound, output bit ok);
    int n;
    n = 0;
    while (kick_active !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    ok = (kick_active === val);
  endtask

  // High samples over one 48-cycle window starting at the next period_start.
  task automatic measure(output int hi);
    bit ok;
    wait_ps(ok);
    hi = ok ? 0 : -1;
    for (int i = 0; i < 48; i++) begin
      if (ok && pwm_out) hi++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad, first, cnt, gap_bad, last;
    rst_n = 1'b0; ena = 1'b1; pid_valid = 1'b0; pid_val = '0;
    repeat (5) @(negedge clk);
    checks++;
    if ({pwm_out, duty_out, kick_active, period_start} !== 7'd0)
      $display("FAIL reset_outputs: got %b required 0", {pwm_out, duty_out, kick_active, period_start});
    else passes++;
    rst_n = 1'b1;
    bad = 0; first = -1; cnt = 0; gap_bad = 0; last = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (pwm_out || duty_out != 4'd0 || kick_active) bad++;
      if (period_start) begin
        if (first < 0) first = k;
        else if (k - last != 48) gap_bad++;
        last = k;
        cnt++;
      end
    end
    checks++;
    if (bad != 0) $display("FAIL idle_outputs: got %0d nonzero samples required 0", bad);
    else passes++;
    checks++;
    if (first != 48) $display("FAIL idle_first_period_start: got %0d required 48", first);
    else passes++;
    checks++;
    if (cnt != 20) $display("FAIL idle_period_count: got %0d required 20", cnt);
    else passes++;
    checks++;
    if (gap_bad != 0) $display("FAIL idle_period_spacing: got %0d bad gaps required 0", gap_bad);
    else passes++;
  endtask

  task automatic test_kick_run();
    bit ok;
    int nk, hi, h1, h2;
    strobe(5'sd8);
    wait_kick(1'b1, 100, ok);
    checks++;
    if (!ok) $display("FAIL kick_entry: got kick_active=%0b required 1", kick_active);
    else passes++;
    nk = 0; hi = 0;
    while (kick_active && nk < 400) begin
      nk++;
      if (pwm_out) hi++;
      @(negedge clk);
    end
    if (pwm_out) hi++;
    checks++;
    if (nk != 192) $display("FAIL kick_length: got %0d required 192", nk);
    else passes++;
    checks++;
    if (hi != 192) $display("FAIL kick_pwm_high: got %0d required 192", hi);
    else passes++;
    checks++;
    if (duty_out !== 4'd8) $display("FAIL run_duty_8: got %0d required 8", duty_out);
    else passes++;
    measure(h1);
    measure(h2);
    checks++;
    if (h1 != 25) $display("FAIL first_run_period: got %0d required 25", h1);
    else passes++;
    checks++;
    if (h2 != 24) $display("FAIL run_high_duty_8: got %0d required 24", h2);
    else passes++;
  endtask

  task automatic test_saturation();
    bit ok;
    int hi, h1;
    strobe(-5'sd5);
    wait_ps(ok);
    checks++;
    if (!ok || duty_out !== 4'd0 || kick_active !== 1'b0)
      $display("FAIL sat_negative_stop: got duty=%0d kick=%0b required duty=0 kick=0", duty_out, kick_active);
    else passes++;
    measure(hi);
    checks++;
    if (hi != 0) $display("FAIL stop_pwm_low: got %0d high required 0", hi);
    else passes++;
    strobe(5'sd1);
    wait_kick(1'b1, 100, ok);
    checks++;
    if (!ok) $display("FAIL sat_min_kick: got kick_active=%0b required 1", kick_active);
    else passes++;
    wait_kick(1'b0, 300, ok);
    checks++;
    if (!ok || duty_out !== 4'd3) $display("FAIL sat_min_duty: got %0d required 3", duty_out);
    else passes++;
    measure(h1);
    measure(hi);
    checks++;
    if (hi != 9) $display("FAIL run_high_duty_3: got %0d required 9", hi);
    else passes++;
    strobe(5'sd15);
    wait_ps(ok);
    checks++;
    if (!ok || duty_out !== 4'd15 || kick_active !== 1'b0)
      $display("FAIL sat_max_duty: got duty=%0d kick=%0b required duty=15 kick=0", duty_out, kick_active);
    else passes++;
    measure(hi);
    checks++;
    if (hi != 45) $display("FAIL run_high_duty_15: got %0d required 45", hi);
    else passes++;
  endtask

  task automatic test_glitch_free();
    bit ok;
    int hi, mid_duty;
    strobe(5'sd8);
    wait_ps(ok);
    checks++;
    if (!ok || duty_out !== 4'd8) $display("FAIL glitch_setup_duty: got %0d required 8", duty_out);
    else passes++;
    hi = 0; mid_duty = -1;
    for (int i = 0; i < 48; i++) begin
      if (pwm_out) hi++;
      if (i == 20) mid_duty = duty_out;
      if (i == 6) begin pid_val = 5'sd4; pid_valid = 1'b1; end
      if (i == 7) pid_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (hi != 24) $display("FAIL glitch_current_period: got %0d required 24", hi);
    else passes++;
    checks++;
    if (mid_duty != 8) $display("FAIL glitch_mid_period_duty: got %0d required 8", mid_duty);
    else passes++;
    measure(hi);
    checks++;
    if (hi != 12) $display("FAIL glitch_next_period: got %0d required 12", hi);
    else passes++;
  endtask

  task automatic test_boundary_collision();
    bit ok;
    int h1, h2;
    strobe(5'sd6);
    wait_ps(ok);
    checks++;
    if (!ok || duty_out !== 4'd6) $display("FAIL collide_setup_duty: got %0d required 6", duty_out);
    else passes++;
    repeat (47) @(negedge clk);
    strobe(5'sd12);
    checks++;
    if (period_start !== 1'b1 || duty_out !== 4'd6)
      $display("FAIL collide_old_shadow: got ps=%0b duty=%0d required ps=1 duty=6", period_start, duty_out);
    else passes++;
    measure(h1);
    measure(h2);
    checks++;
    if (h1 != 18) $display("FAIL collide_following_period: got %0d required 18", h1);
    else passes++;
    checks++;
    if (h2 != 36 || duty_out !== 4'd12) $display("FAIL collide_period_after: got %0d high duty=%0d required 36 duty=12", h2, duty_out);
    else passes++;
  endtask

  task automatic test_reset_mid_kick();
    bit ok;
    int n, kicks;
    strobe(5'sd0);
    wait_ps(ok);
    strobe(5'sd10);
    wait_kick(1'b1, 100, ok);
    repeat (50) @(negedge clk);
    checks++;
    if (!ok || kick_active !== 1'b1 || pwm_out !== 1'b1)
      $display("FAIL mid_kick_setup: got kick=%0b pwm=%0b required 1 1", kick_active, pwm_out);
    else passes++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({pwm_out, duty_out, kick_active, period_start} !== 7'd0)
      $display("FAIL mid_kick_reset_outputs: got %b required 0", {pwm_out, duty_out, kick_active, period_start});
    else passes++;
    n = 0;
    while (!period_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 48) $display("FAIL mid_kick_reset_counters: got %0d cycles to period_start required 48", n);
    else passes++;
    kicks = 0;
    for (int i = 0; i < 100; i++) begin
      if (kick_active || pwm_out) kicks++;
      @(negedge clk);
    end
    checks++;
    if (kicks != 0) $display("FAIL mid_kick_reset_stop: got %0d active samples required 0", kicks);
    else passes++;
  endtask

  task automatic test_ena_freeze();
    bit ok;
    int hi, bad, first;
    strobe(5'sd8);
    wait_kick(1'b1, 100, ok);
    wait_kick(1'b0, 300, ok);
    measure(hi);
    measure(hi);
    checks++;
    if (hi != 24) $display("FAIL ena_setup_run: got %0d required 24", hi);
    else passes++;
    hi = 0; bad = 0; first = -1;
    for (int i = 0; i <= 68; i++) begin
      if (i > 0 && period_start && first < 0) first = i;
      if (i < 68 && pwm_out) hi++;
      if (i >= 11 && i <= 30 && (pwm_out || period_start)) bad++;
      if (i == 10) ena = 1'b0;
      if (i == 30) ena = 1'b1;
      if (i < 68) @(negedge clk);
    end
    checks++;
    if (bad != 0) $display("FAIL ena_low_forced_zero: got %0d nonzero samples required 0", bad);
    else passes++;
    checks++;
    if (first != 68) $display("FAIL ena_period_resume: got period_start at %0d required 68", first);
    else passes++;
    checks++;
    if (hi != 24) $display("FAIL ena_period_high: got %0d required 24", hi);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n = 1'b0; ena = 1'b1; pid_valid = 1'b0; pid_val = '0;
    @(negedge clk);
    test_reset();
    test_kick_run();
    test_saturation();
    test_glitch_free();
    test_boundary_collision();
    test_reset_mid_kick();
    test_ena_freeze();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
